alu_out_sel: RTL and testbench

Parametrised, registered result-select stage for the MIPS-subset ALU datapath. It chooses among ALU, shifter and HI/LO sources by function code, owns the HI/LO register pair loaded from a multi-cycle multiplier, and stalls MFHI/MFLO until a pending MULTU completes. It sits between the execute units and writeback, with valid/ready handshakes on both sides and one output register.

---
 rtl/alu_pkg.sv | 40 ++++
 rtl/alu_out_sel_if.sv | 27 ++
 rtl/hilo_reg.sv | 60 ++++++
 rtl/alu_out_sel.sv | 107 ++++++++++
 tb/tb_alu_out_sel.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the alu_out_sel result-select stage: function codes,
// result-source enum and the funct-to-source decode.
package alu_pkg;

   localparam logic [5:0] F_AND   = 6'b100100;
   localparam logic [5:0] F_OR    = 6'b100101;
   localparam logic [5:0] F_ADD   = 6'b100000;
   localparam logic [5:0] F_SUB   = 6'b100010;
   localparam logic [5:0] F_SLT   = 6'b101010;
   localparam logic [5:0] F_SRL   = 6'b000010;
   localparam logic [5:0] F_MULTU = 6'b011001;
   localparam logic [5:0] F_MFHI  = 6'b010000;
   localparam logic [5:0] F_MFLO  = 6'b010010;

   typedef enum logic [2:0] {
      SRC_ALU,
      SRC_SHIFT,
      SRC_HI,
      SRC_LO,
      SRC_NONE
   } src_e;

   // MULTU and unknown codes both map to SRC_NONE: neither captures a source.
   function automatic src_e decode_src(input logic [5:0] funct);
      src_e src;
      case (funct)
         F_AND, F_OR, F_ADD, F_SUB, F_SLT: src = SRC_ALU;
         F_SRL:                            src = SRC_SHIFT;
         F_MFHI:                           src = SRC_HI;
         F_MFLO:                           src = SRC_LO;
         default:                          src = SRC_NONE;
      endcase
      return src;
   endfunction

   function automatic logic is_known(input logic [5:0] funct);
      return (decode_src(funct) != SRC_NONE) || (funct == F_MULTU);
   endfunction

endpackage

// File: rtl/alu_out_sel_if.sv
// Bundle of the operation, multiplier and result handshake signals of alu_out_sel.
interface alu_out_sel_if #(parameter int WIDTH = 32);

   logic               op_valid;
   logic               op_ready;
   logic [5:0]         funct;
   logic [WIDTH-1:0]   alu_res;
   logic [WIDTH-1:0]   shift_res;
   logic               mul_start;
   logic               mul_done;
   logic [2*WIDTH-1:0] mul_prod;
   logic               out_valid;
   logic               out_ready;
   logic [WIDTH-1:0]   data_out;
   logic               err;

   modport master (
      output op_valid, funct, alu_res, shift_res, mul_done, mul_prod, out_ready,
      input  op_ready, mul_start, out_valid, data_out, err
   );

   modport slave (
      input  op_valid, funct, alu_res, shift_res, mul_done, mul_prod, out_ready,
      output op_ready, mul_start, out_valid, data_out, err
   );

endinterface

// File: rtl/hilo_reg.sv
// HI/LO register pair with the outstanding-multiply flag, timeout counter and
// single-cycle spurious-completion / timeout indications.
module hilo_reg
   import alu_pkg::*;
#(
   parameter int WIDTH       = 32,
   parameter int MUL_TIMEOUT = 64
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               i_start,
   input  logic               i_done,
   input  logic [2*WIDTH-1:0] i_prod,
   output logic [WIDTH-1:0]   o_hi,
   output logic [WIDTH-1:0]   o_lo,
   output logic               o_pending,
   output logic               o_spurious,
   output logic               o_timeout
);

   localparam int             CW   = $clog2(MUL_TIMEOUT + 1);
   localparam logic [CW-1:0]  TMAX = CW'(MUL_TIMEOUT);

   logic [WIDTH-1:0] r_hi;
   logic [WIDTH-1:0] r_lo;
   logic             r_pending;
   logic [CW-1:0]    r_cnt;

   // NOTE: all state uses non-blocking assignments so every register samples
   // pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_hi      <= '0;
         r_lo      <= '0;
         r_pending <= 1'b0;
         r_cnt     <= '0;
      end else begin
         if (i_done && r_pending) begin
            r_hi <= i_prod[2*WIDTH-1:WIDTH];
            r_lo <= i_prod[WIDTH-1:0];
         end
         // A new start wins over a completion landing in the same cycle.
         if (i_start) begin
            r_pending <= 1'b1;
            r_cnt     <= '0;
         end else if (i_done) begin
            r_pending <= 1'b0;
         end else if (r_pending && (r_cnt != TMAX)) begin
            r_cnt <= r_cnt + 1'b1;
         end
      end
   end

   assign o_hi       = r_hi;
   assign o_lo       = r_lo;
   assign o_pending  = r_pending;
   assign o_spurious = i_done && !r_pending;
   assign o_timeout  = r_pending && !i_done && !i_start && (r_cnt == TMAX - 1'b1);

endmodule

// File: rtl/alu_out_sel.sv
// Registered result-select stage: decode, handshake and output register.
// Optional ALU_HILO_BYPASS_EN forwards mul_prod to MFHI/MFLO in the mul_done cycle.
module alu_out_sel
   import alu_pkg::*;
#(
   parameter int WIDTH       = 32,
   parameter int MUL_TIMEOUT = 64
) (
   input  logic         clk,
   input  logic         rst_n,
   alu_out_sel_if.slave bus
);

   logic             r_out_valid;
   logic [WIDTH-1:0] r_data;
   logic             r_err;

   logic [WIDTH-1:0] w_hi_q;
   logic [WIDTH-1:0] w_lo_q;
   logic [WIDTH-1:0] w_hi;
   logic [WIDTH-1:0] w_lo;
   logic             w_pending;
   logic             w_spurious;
   logic             w_timeout;
   logic             w_busy;
   logic             w_stall;
   logic             w_accept;
   logic             w_mul_start;
   logic             w_is_multu;
   logic             w_is_mf;
   logic             w_known;
   logic [WIDTH-1:0] w_sel;
   src_e             w_src;

   assign w_src      = decode_src(bus.funct);
   assign w_known    = is_known(bus.funct);
   assign w_is_multu = (bus.funct == F_MULTU);
   assign w_is_mf    = (bus.funct == F_MFHI) || (bus.funct == F_MFLO);

`ifdef ALU_HILO_BYPASS_EN
   assign w_busy = w_pending && !bus.mul_done;
   assign w_hi   = (w_pending && bus.mul_done) ? bus.mul_prod[2*WIDTH-1:WIDTH] : w_hi_q;
   assign w_lo   = (w_pending && bus.mul_done) ? bus.mul_prod[WIDTH-1:0]       : w_lo_q;
`else
   assign w_busy = w_pending;
   assign w_hi   = w_hi_q;
   assign w_lo   = w_lo_q;
`endif

   assign w_stall     = w_busy && (w_is_multu || w_is_mf);
   assign bus.op_ready = !w_stall && (!r_out_valid || bus.out_ready);
   assign w_accept    = bus.op_valid && bus.op_ready;
   assign w_mul_start = w_accept && w_is_multu;

   // NOTE: every branch assigns w_sel so no latch is inferred.
   always_comb begin
      w_sel = '0;
      case (w_src)
         SRC_ALU:   w_sel = bus.alu_res;
         SRC_SHIFT: w_sel = bus.shift_res;
         SRC_HI:    w_sel = w_hi;
         SRC_LO:    w_sel = w_lo;
         default:   w_sel = '0;
      endcase
   end

   hilo_reg #(
      .WIDTH       (WIDTH),
      .MUL_TIMEOUT (MUL_TIMEOUT)
   ) u_hilo (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_start    (w_mul_start),
      .i_done     (bus.mul_done),
      .i_prod     (bus.mul_prod),
      .o_hi       (w_hi_q),
      .o_lo       (w_lo_q),
      .o_pending  (w_pending),
      .o_spurious (w_spurious),
      .o_timeout  (w_timeout)
   );

   // MULTU produces no beat, so it only lets an accepted result drain.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_out_valid <= 1'b0;
         r_data      <= '0;
         r_err       <= 1'b0;
      end else begin
         if (w_accept && !w_is_multu) begin
            r_out_valid <= 1'b1;
            r_data      <= w_sel;
         end else if (bus.out_ready) begin
            r_out_valid <= 1'b0;
         end
         if ((w_accept && !w_known) || w_spurious || w_timeout) begin
            r_err <= 1'b1;
         end
      end
   end

   assign bus.mul_start = w_mul_start;
   assign bus.out_valid = r_out_valid;
   assign bus.data_out  = r_data;
   assign bus.err       = r_err;

endmodule

// File: tb/tb_alu_out_sel.sv
// Self-checking bench for alu_out_sel: directed scenarios plus randomized traffic
// compared against a cycle-level behavioural model.
module tb_alu_out_sel;
   import alu_pkg::*;

   localparam int W   = 32;
   localparam int TMO = 16;
`ifdef ALU_HILO_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   alu_out_sel_if #(.WIDTH(W)) bus ();

   alu_out_sel #(.WIDTH(W), .MUL_TIMEOUT(TMO)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int n_checks = 0;
   int n_fail   = 0;

   // Behavioural model state
   bit           m_pending, m_ov, m_err;
   logic [W-1:0] m_hi, m_lo, m_data;
   int           m_age;
   bit           last_start;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic logic [W-1:0] result_of(input logic [5:0] f, input logic [W-1:0] a,
                                              input logic [W-1:0] s);
      case (f)
         F_AND, F_OR, F_ADD, F_SUB, F_SLT: return a;
         F_SRL:                            return s;
         F_MFHI:                           return m_hi;
         F_MFLO:                           return m_lo;
         default:                          return '0;
      endcase
   endfunction

   task automatic check_outputs();
      check("out_valid", 64'(bus.out_valid), 64'(m_ov));
      check("data_out",  64'(bus.data_out),  64'(m_data));
      check("err",       64'(bus.err),       64'(m_err));
   endtask

   // One clock cycle: drive at negedge, check handshake, advance model, check outputs.
   task automatic step(input logic v, input logic [5:0] f, input logic [W-1:0] a,
                       input logic [W-1:0] s, input logic d, input logic [2*W-1:0] p,
                       input logic ordy);
      bit mf, stall, rdy, acc, old_pend;
      bus.op_valid  = v;
      bus.funct     = f;
      bus.alu_res   = a;
      bus.shift_res = s;
      bus.mul_done  = d;
      bus.mul_prod  = p;
      bus.out_ready = ordy;
      #1;
      mf    = (f == F_MFHI) || (f == F_MFLO);
      stall = m_pending && !(BYP && d) && (mf || f == F_MULTU);
      rdy   = !stall && (!m_ov || ordy);
      acc   = v && rdy;
      last_start = acc && (f == F_MULTU);
      check("op_ready",  64'(bus.op_ready),  64'(rdy));
      check("mul_start", 64'(bus.mul_start), 64'(last_start));
      @(posedge clk);
      old_pend = m_pending;
      if (old_pend && !d) begin
         m_age++;
         if (m_age == TMO) m_err = 1'b1;
      end
      if (d && old_pend) begin
         m_hi = p[2*W-1:W];
         m_lo = p[W-1:0];
         m_pending = 1'b0;
      end
      if (d && !old_pend) m_err = 1'b1;
      if (acc && f == F_MULTU) begin
         m_pending = 1'b1;
         m_age     = 0;
         if (ordy) m_ov = 1'b0;
      end else if (acc) begin
         m_ov   = 1'b1;
         m_data = result_of(f, a, s);
         if (!is_known(f)) m_err = 1'b1;
      end else if (ordy) begin
         m_ov = 1'b0;
      end
      @(negedge clk);
      check_outputs();
   endtask

   task automatic idle(input int n, input logic ordy);
      for (int i = 0; i < n; i++) step(1'b0, F_ADD, '0, '0, 1'b0, '0, ordy);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n         = 1'b0;
      bus.op_valid  = 1'b0;
      bus.funct     = F_ADD;
      bus.alu_res   = '0;
      bus.shift_res = '0;
      bus.mul_done  = 1'b0;
      bus.mul_prod  = '0;
      bus.out_ready = 1'b0;
      m_pending = 0; m_ov = 0; m_err = 0; m_hi = '0; m_lo = '0; m_data = '0; m_age = 0;
      #2;
      check_outputs();
      check("rst_mul_start", 64'(bus.mul_start), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("rst_op_ready", 64'(bus.op_ready), 64'd1);
      @(negedge clk);
   endtask

   initial begin
      int           mul_cd;
      logic [W-1:0] ma, mb;
      logic [2*W-1:0] prod;
      logic [5:0]   codes [9];
      codes = '{F_AND, F_OR, F_ADD, F_SUB, F_SLT, F_SRL, F_MULTU, F_MFHI, F_MFLO};

      // Reset and a simple ADD
      do_reset();
      step(1'b1, F_ADD, 32'h0000_0005, '0, 1'b0, '0, 1'b1);
      check("add_data", 64'(bus.data_out), 64'h5);
      check("add_err",  64'(bus.err),      64'h0);

      // Backpressure: SRL held while out_ready low, ADD blocked
      step(1'b1, F_SRL, '0, 32'h8000_0000, 1'b0, '0, 1'b1);
      for (int i = 0; i < 3; i++) begin
         step(1'b1, F_ADD, 32'h0000_0007, '0, 1'b0, '0, 1'b0);
         check("srl_hold", 64'(bus.data_out), 64'h8000_0000);
      end
      step(1'b1, F_ADD, 32'h0000_0007, '0, 1'b0, '0, 1'b1);
      check("add_after_hold", 64'(bus.data_out), 64'h7);

      // MULTU then MFHI stalled until the product lands
      step(1'b1, F_MULTU, '0, '0, 1'b0, '0, 1'b1);
      for (int i = 0; i < 9; i++) step(1'b1, F_MFHI, '0, '0, 1'b0, '0, 1'b1);
      step(1'b1, F_MFHI, '0, '0, 1'b1, 64'h0000_0001_FFFF_FFFE, 1'b1);
      if (!BYP) step(1'b1, F_MFHI, '0, '0, 1'b0, '0, 1'b1);
      check("mfhi", 64'(bus.data_out), 64'h1);
      step(1'b1, F_MFLO, '0, '0, 1'b0, '0, 1'b1);
      check("mflo", 64'(bus.data_out), 64'hFFFF_FFFE);

      // ALU ops proceed while a multiply is outstanding; a second MULTU stalls
      step(1'b1, F_MULTU, '0, '0, 1'b0, '0, 1'b1);
      step(1'b1, F_ADD, 32'h0000_0011, '0, 1'b0, '0, 1'b1);
      check("add_pending", 64'(bus.data_out), 64'h11);
      step(1'b1, F_OR, 32'h0000_0022, '0, 1'b0, '0, 1'b1);
      check("or_pending", 64'(bus.data_out), 64'h22);
      for (int i = 0; i < 3; i++) step(1'b1, F_MULTU, '0, '0, 1'b0, '0, 1'b1);
      step(1'b1, F_MULTU, '0, '0, 1'b1, 64'h0000_0002_0000_0003, 1'b1);
      step(1'b1, F_MULTU, '0, '0, 1'b0, '0, 1'b1);
      step(1'b0, F_ADD, '0, '0, 1'b1, 64'h0000_0004_0000_0005, 1'b1);

      // Randomized traffic against the model; multiplier emulated here
      do_reset();
      mul_cd = 0;
      prod   = '0;
      for (int c = 0; c < 400; c++) begin
         logic d;
         d = (mul_cd == 1);
         step(($urandom_range(0, 4) != 0), codes[$urandom_range(0, 8)], $urandom, $urandom,
              d, prod, ($urandom_range(0, 3) != 0));
         if (mul_cd > 0) mul_cd--;
         if (last_start) begin
            mul_cd = $urandom_range(1, 12);
            ma     = $urandom;
            mb     = $urandom;
            prod   = 64'(ma) * 64'(mb);
         end
      end
      check("rand_no_err", 64'(bus.err), 64'h0);

      // Spurious mul_done and unknown funct
      do_reset();
      step(1'b0, F_ADD, '0, '0, 1'b1, 64'hDEAD_BEEF_CAFE_F00D, 1'b1);
      check("spurious_err", 64'(bus.err), 64'h1);
      step(1'b1, F_MFHI, '0, '0, 1'b0, '0, 1'b1);
      check("hi_unchanged", 64'(bus.data_out), 64'h0);
      step(1'b1, F_ADD, 32'h55, '0, 1'b0, '0, 1'b1);
      step(1'b1, F_MFLO, '0, '0, 1'b0, '0, 1'b1);
      check("lo_unchanged", 64'(bus.data_out), 64'h0);
      step(1'b1, 6'h3F, 32'h1234, 32'h5678, 1'b0, '0, 1'b1);
      check("unknown_data",  64'(bus.data_out),  64'h0);
      check("unknown_valid", 64'(bus.out_valid), 64'h1);

      // Unknown funct alone raises err
      do_reset();
      step(1'b1, 6'h3F, 32'h1234, '0, 1'b0, '0, 1'b1);
      check("unknown_err", 64'(bus.err), 64'h1);

      // Multiply timeout, then reset mid-pending
      do_reset();
      step(1'b1, F_MULTU, '0, '0, 1'b0, '0, 1'b1);
      idle(TMO - 1, 1'b1);
      check("tmo_before", 64'(bus.err), 64'h0);
      idle(1, 1'b1);
      check("tmo_at", 64'(bus.err), 64'h1);
      step(1'b1, F_MFHI, '0, '0, 1'b0, '0, 1'b1);
      do_reset();
      check("rst_err", 64'(bus.err), 64'h0);
      step(1'b1, F_MFLO, '0, '0, 1'b0, '0, 1'b1);
      check("mflo_after_rst", 64'(bus.data_out), 64'h0);
      step(1'b0, F_ADD, '0, '0, 1'b1, 64'h1111_2222_3333_4444, 1'b1);
      check("late_done_err", 64'(bus.err), 64'h1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
